// File: rtl/mult_seq_16x16.sv
// ============================================================================
// mult_seq_16x16
//
// Sequential 16x16 -> 32 multiplier that time-shares one external 8x8
// combinational multiplier over four clocks. Each operand is split into
// bytes, one partial product is requested per MUL cycle, and the product is
// built up in a 32-bit accumulator. The result is held on a valid/ready
// output until the consumer takes it.
//
// Timeline: input handshake edge -> 4 MUL edges -> DONE (out_valid=1)
//           -> output handshake edge -> IDLE. At least 6 clocks per operation.
//
// Build option:
//   MULT_SEQ_SIGNED_EN  defined: a, b and product are two's complement. The
//                       operand magnitudes are multiplied and the result is
//                       negated on entry to DONE when the signs differ.
//                       undefined (default): purely unsigned, no sign logic.
//
// Parameters:
//   CNT_W      width of the completed-operation counter (wraps silently)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       16-bit multiplicand / multiplier
//   mul_a      8-bit operand A to the external multiplier
//   mul_b      8-bit operand B to the external multiplier
//   mul_p      16-bit product returned by the external multiplier, same cycle
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   product    32-bit result, holds last delivered value outside DONE
//   busy       high whenever the FSM is not IDLE
//   op_count   number of results delivered
// ============================================================================
module mult_seq_16x16 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      product,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        k_q;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [31:0]       acc_q;
    logic [31:0]       product_q;
    logic [CNT_W-1:0]  op_count_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [31:0]       pp_d;      // current partial product, already shifted
    logic [31:0]       acc_d;     // accumulator after adding pp_d
    logic [31:0]       result_d;  // value loaded into product on entry to DONE
    logic [15:0]       a_mag_d;
    logic [15:0]       b_mag_d;

`ifdef MULT_SEQ_SIGNED_EN
    logic              sign_q;
    logic              sign_d;

    // 0x8000 negates to itself, which is exactly its unsigned magnitude.
    assign a_mag_d  = a[15] ? (~a + 16'd1) : a;
    assign b_mag_d  = b[15] ? (~b + 16'd1) : b;
    assign sign_d   = a[15] ^ b[15];
    assign result_d = sign_q ? (~acc_d + 32'd1) : acc_d;
`else
    assign a_mag_d  = a;
    assign b_mag_d  = b;
    assign result_d = acc_d;
`endif

    // Byte selection: k[1] picks the high byte of A, k[0] the high byte of B.
    always_comb begin
        mul_a = 8'd0;
        mul_b = 8'd0;
        if (state_q == MUL) begin
            mul_a = k_q[1] ? a_q[15:8] : a_q[7:0];
            mul_b = k_q[0] ? b_q[15:8] : b_q[7:0];
        end
    end

    always_comb begin
        pp_d = {16'd0, mul_p};
        case (k_q)
            2'd0:    pp_d = {16'd0, mul_p};
            2'd1,
            2'd2:    pp_d = {8'd0, mul_p, 8'd0};
            default: pp_d = {mul_p, 16'd0};
        endcase
        // Carry out of bit 31 is dropped by the 32-bit sum.
        acc_d = acc_q + pp_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            acc_q       <= 32'd0;
            product_q   <= 32'd0;
            op_count_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_mag_d;
                        b_q        <= b_mag_d;
`ifdef MULT_SEQ_SIGNED_EN
                        sign_q     <= sign_d;
`endif
                        acc_q      <= 32'd0;
                        k_q        <= 2'd0;
                        state_q    <= MUL;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        product_q   <= result_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        op_count_q  <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;
    assign op_count  = op_count_q;

endmodule
